// File: rtl/mult_add_datapath.sv
// Repeated-addition datapath: accumulator X, iteration counter K and a result register.
// The optional protocol checker is enabled by defining DP_PROTOCOL_CHECK_EN.
module mult_add_datapath #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  parameter int KW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alpha,
  input  logic             beta,
  input  logic             gamma,
  input  logic             z,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             L,
  output logic [WIDTH-1:0] x,
  output logic [KW-1:0]    k,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             overflow,
  output logic             proto_err
);

  localparam logic [KW-1:0] K_LAST = KW'(COUNT - 1);
  localparam logic [KW-1:0] K_MAX  = KW'(COUNT);

  logic [WIDTH-1:0] x_q, x_d;
  logic [KW-1:0]    k_q, k_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             rv_q, rv_d;
  logic             zd_q;
  logic [WIDTH:0]   sum;
  logic             capture;

  // Carry-out lives in the extra top bit of the widened sum.
  assign sum     = {1'b0, x_q} + {1'b0, a};
  assign capture = z & ~zd_q;

  always_comb begin
    x_d   = x_q;
    k_d   = k_q;
    ovf_d = ovf_q;
    res_d = res_q;
    rv_d  = rv_q;
    if (alpha) begin
      x_d   = b;
      k_d   = '0;
      ovf_d = 1'b0;
    end else begin
      if (beta) begin
        x_d   = sum[WIDTH-1:0];
        ovf_d = ovf_q | sum[WIDTH];
      end
      if (gamma && (k_q < K_MAX)) begin
        k_d = k_q + 1'b1;
      end
    end
    if (capture) begin
      res_d = x_q;
      rv_d  = 1'b1;
    end
    // A new run always invalidates the previous result.
    if (alpha) begin
      rv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q   <= '0;
      k_q   <= '0;
      ovf_q <= 1'b0;
      res_q <= '0;
      rv_q  <= 1'b0;
      zd_q  <= 1'b0;
    end else begin
      x_q   <= x_d;
      k_q   <= k_d;
      ovf_q <= ovf_d;
      res_q <= res_d;
      rv_q  <= rv_d;
      zd_q  <= z;
    end
  end

`ifdef DP_PROTOCOL_CHECK_EN
  logic perr_q, perr_d;
  logic illegal;

  // Legal controller only ever issues beta and gamma together, never alongside alpha.
  assign illegal = (alpha & beta) | (alpha & gamma) | (beta ^ gamma) |
                   (gamma & (k_q == K_MAX)) | (z & (alpha | beta));

  always_comb begin
    perr_d = perr_q | illegal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign proto_err = perr_q;
`else
  assign proto_err = 1'b0;
`endif

  assign L            = (k_q == K_LAST);
  assign x            = x_q;
  assign k            = k_q;
  assign result       = res_q;
  assign result_valid = rv_q;
  assign overflow     = ovf_q;

endmodule
